// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcode constants, FSM state encoding and dispatch helper for alu_mc
package alu_mc_pkg;

    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_SHL = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_SHR = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_SRA = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_CMP = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_MUL = 4'd9;
    localparam logic [OPCODE_W-1:0] OP_DIV = 4'd10;
    localparam logic [OPCODE_W-1:0] OP_REM = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL always iterates; DIV/REM only iterate when the divisor is nonzero,
    // a zero divisor is resolved in a single cycle.
    function automatic logic is_iterative(input logic [OPCODE_W-1:0] op,
                                          input logic b_nonzero);
        return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_REM)) && b_nonzero);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_is_mul,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(DATA_WIDTH);

    // hi/lo are shared: for MUL they are the upper/lower product halves
    // (lo starts as the multiplier), for DIV they are remainder/quotient
    // (lo starts as the dividend). r_opnd is multiplicand or divisor.
    logic                  r_busy;
    logic                  r_is_mul;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_opnd;

    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH:0]   w_div_shift;
    logic [DATA_WIDTH:0]   w_div_diff;
    logic                  w_div_ge;
    logic [DATA_WIDTH-1:0] w_hi_next;
    logic [DATA_WIDTH-1:0] w_lo_next;

    // One iteration step; the next-state values double as the final result
    // so the parent can capture them on the last iteration edge.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
        w_div_shift = {r_hi, r_lo[DATA_WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (r_is_mul) begin
            w_hi_next = w_mul_sum[DATA_WIDTH:1];
            w_lo_next = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
        end else begin
            w_hi_next = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
            w_lo_next = {r_lo[DATA_WIDTH-2:0], w_div_ge};
        end
    end

    assign o_done = r_busy && (r_count == CW'(DATA_WIDTH - 1));
    assign o_hi   = w_hi_next;
    assign o_lo   = w_lo_next;

    // Load operands on start, then run exactly DATA_WIDTH iterations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_mul <= 1'b0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_mul <= i_is_mul;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= i_is_mul ? i_b : i_a;
            r_opnd   <= i_is_mul ? i_a : i_b;
        end else if (r_busy) begin
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_count <= r_count + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and status flags
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [OP_WIDTH-1:0]   op_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  overflow_flag,
    output logic                  negative_flag,
    output logic                  div_zero_flag
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int MSB = DATA_WIDTH - 1;

    state_t                r_state;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_carry;
    logic                  r_ovf;
    logic                  r_neg;
    logic                  r_dz;
    logic                  r_out_valid;
    logic                  r_in_ready;

    logic                  w_accept;
    logic                  w_multi;
    logic                  w_start;
    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH:0]   w_add;
    logic [DATA_WIDTH:0]   w_sub;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_alu_carry;
    logic                  w_alu_ovf;
    logic                  w_alu_dz;
    logic                  w_seq_done;
    logic [DATA_WIDTH-1:0] w_seq_hi;
    logic [DATA_WIDTH-1:0] w_seq_lo;
    logic [DATA_WIDTH-1:0] w_md_res;
    logic                  w_md_carry;

    assign w_accept = (r_state == ST_IDLE) && r_in_ready && in_valid;
    assign w_multi  = is_iterative(op_code, |b);
    assign w_start  = w_accept && w_multi;
    assign w_shamt  = b[SHW-1:0];
    assign w_add    = {1'b0, a} + {1'b0, b};
    assign w_sub    = {1'b0, a} - {1'b0, b};

    // Single-cycle datapath, evaluated straight from the live operands so the
    // result can be registered on the accept edge.
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        w_alu_dz    = 1'b0;
        case (op_code)
            OP_ADD: begin
                w_alu_res   = w_add[MSB:0];
                w_alu_carry = w_add[DATA_WIDTH];
                w_alu_ovf   = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_alu_res   = w_sub[MSB:0];
                w_alu_carry = w_sub[DATA_WIDTH];
                w_alu_ovf   = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
            end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_SHL: w_alu_res = a << w_shamt;
            OP_SHR: w_alu_res = a >> w_shamt;
            OP_SRA: w_alu_res = $signed(a) >>> w_shamt;
            OP_CMP: w_alu_res = DATA_WIDTH'(a == b);
            // Only reached with b == 0; nonzero divisors take the iterative path.
            OP_DIV: begin
                w_alu_res = '1;
                w_alu_dz  = 1'b1;
            end
            OP_REM: begin
                w_alu_res = a;
                w_alu_dz  = 1'b1;
            end
            default: w_alu_res = '0;
        endcase
    end

    // Pick the iterative result: quotient/product-low live in lo, remainder in hi.
    always_comb begin
        w_md_res   = (r_op == OP_REM) ? w_seq_hi : w_seq_lo;
        w_md_carry = (r_op == OP_MUL) && (|w_seq_hi);
    end

    alu_muldiv_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_is_mul (op_code == OP_MUL),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_seq_done),
        .o_hi     (w_seq_hi),
        .o_lo     (w_seq_lo)
    );

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_in_ready) begin
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_op       <= op_code;
                        r_in_ready <= 1'b0;
                        if (w_multi) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_carry     <= w_alu_carry;
                            r_ovf       <= w_alu_ovf;
                            r_neg       <= w_alu_res[MSB];
                            r_dz        <= w_alu_dz;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_seq_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_md_res;
                        r_zero      <= (w_md_res == '0);
                        r_carry     <= w_md_carry;
                        r_ovf       <= 1'b0;
                        r_neg       <= w_md_res[MSB];
                        r_dz        <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign result        = r_result;
    assign zero_flag     = r_zero;
    assign carry_flag    = r_carry;
    assign overflow_flag = r_ovf;
    assign negative_flag = r_neg;
    assign div_zero_flag = r_dz;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc at widths 8, 16 and 32
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic [63:0] a_v         [3];
    logic [63:0] b_v         [3];
    logic [3:0]  op_v        [3];
    wire         in_ready_v  [3];
    wire         out_valid_v [3];
    wire  [63:0] res_v       [3];
    wire  [4:0]  flg_v       [3];

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = 8 << g;
        logic [W-1:0] w_res;
        logic w_rdy, w_ov, w_z, w_c, w_v, w_n, w_dz;
        alu_mc #(.DATA_WIDTH(W), .OP_WIDTH(4)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid_v[g]),
            .in_ready      (w_rdy),
            .a             (a_v[g][W-1:0]),
            .b             (b_v[g][W-1:0]),
            .op_code       (op_v[g]),
            .out_valid     (w_ov),
            .out_ready     (out_ready_v[g]),
            .result        (w_res),
            .zero_flag     (w_z),
            .carry_flag    (w_c),
            .overflow_flag (w_v),
            .negative_flag (w_n),
            .div_zero_flag (w_dz)
        );
        assign in_ready_v[g]  = w_rdy;
        assign out_valid_v[g] = w_ov;
        assign res_v[g]       = 64'(w_res);
        assign flg_v[g]       = {w_z, w_c, w_v, w_n, w_dz};
    end

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
    } exp_t;

    // Reference model: arithmetic on wide integers, flags from signed ranges.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] op);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] res;
        logic [127:0] p;
        longint      sa, sb, s, lo_lim, hi_lim;
        int          sh;
        logic        c, v, dz;
        mask   = (64'd1 << w) - 64'd1;
        sa     = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb     = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        lo_lim = -(longint'(1) << (w - 1));
        hi_lim = (longint'(1) << (w - 1)) - 1;
        sh     = int'(b % 64'(w));
        c = 1'b0; v = 1'b0; dz = 1'b0; res = 64'd0; e.lat = 1;
        case (op)
            4'd0: begin
                res = a + b; c = res[w]; res = res & mask;
                s = sa + sb; v = (s > hi_lim) || (s < lo_lim);
            end
            4'd1: begin
                res = (a - b) & mask; c = (a < b);
                s = sa - sb; v = (s > hi_lim) || (s < lo_lim);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (a << sh) & mask;
            4'd6: res = a >> sh;
            4'd7: res = 64'(sa >>> sh) & mask;
            4'd8: res = (a == b) ? 64'd1 : 64'd0;
            4'd9: begin
                p = 128'(a) * 128'(b); res = p[63:0] & mask;
                c = ((p >> w) != 128'd0); e.lat = w + 1;
            end
            4'd10: if (b == 0) begin res = mask; dz = 1'b1; end
                   else begin res = a / b; e.lat = w + 1; end
            4'd11: if (b == 0) begin res = a; dz = 1'b1; end
                   else begin res = a % b; e.lat = w + 1; end
            default: res = 64'd0;
        endcase
        e.res = res;
        e.flg = {res == 64'd0, c, v, res[w-1], dz};
        return e;
    endfunction

    // One request/response transaction; entered and left on a falling edge.
    task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input bit ack,
                          output logic [63:0] res, output logic [4:0] flg,
                          output int lat, output logic post_valid);
        int guard = 0;
        while (in_ready_v[k] !== 1'b1 && guard < 50) begin
            @(negedge clk); guard++;
        end
        if (guard >= 50) begin
            total_cnt++;
            $display("FAIL in_ready_timeout k=%0d: got %b expected 1", k, in_ready_v[k]);
        end
        a_v[k] = a; b_v[k] = b; op_v[k] = op; in_valid_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        a_v[k] = {$urandom(), $urandom()};
        b_v[k] = {$urandom(), $urandom()};
        op_v[k] = 4'($urandom());
        lat = 1;
        while (out_valid_v[k] !== 1'b1 && lat < 200) begin
            @(negedge clk); lat++;
        end
        res = res_v[k];
        flg = flg_v[k];
        post_valid = out_valid_v[k];
        if (ack) begin
            out_ready_v[k] = 1'b1;
            @(negedge clk);
            out_ready_v[k] = 1'b0;
            post_valid = out_valid_v[k];
        end
    endtask

    task automatic test_reset();
        logic [63:0] r; logic [4:0] f; int l; logic pv;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({out_valid_v[0], res_v[0], flg_v[0]} !== 70'd0)
            $display("FAIL reset_hold: got ov=%b res=%h flg=%b expected all 0",
                     out_valid_v[0], res_v[0], flg_v[0]);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready_v[0], in_ready_v[1], in_ready_v[2]} !== 3'b111)
            $display("FAIL reset_in_ready: got %b%b%b expected 111",
                     in_ready_v[0], in_ready_v[1], in_ready_v[2]);
        else pass_cnt++;
        run_op(0, 64'hFF, 64'h01, 4'd0, 1'b0, r, f, l, pv);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid_v[0], res_v[0], flg_v[0]} !== 70'd0)
            $display("FAIL reset_async: got ov=%b res=%h flg=%b expected all 0",
                     out_valid_v[0], res_v[0], flg_v[0]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready_v[0] !== 1'b1)
            $display("FAIL reset_release_ready: got %b expected 1", in_ready_v[0]);
        else pass_cnt++;
    endtask

    typedef struct {
        int          k;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[11];
        logic [63:0] r; logic [4:0] f; int l; logic pv;
        tbl[0]  = '{0, 64'hFF, 64'h01, 4'd0,  64'h00,   5'b11000, 1};
        tbl[1]  = '{0, 64'h80, 64'h01, 4'd1,  64'h7F,   5'b00100, 1};
        tbl[2]  = '{0, 64'h80, 64'h03, 4'd7,  64'hF0,   5'b00010, 1};
        tbl[3]  = '{0, 64'h10, 64'h11, 4'd9,  64'h10,   5'b01000, 9};
        tbl[4]  = '{0, 64'd200, 64'd7, 4'd10, 64'd28,   5'b00000, 9};
        tbl[5]  = '{0, 64'd200, 64'd7, 4'd11, 64'd4,    5'b00000, 9};
        tbl[6]  = '{0, 64'h2A, 64'h00, 4'd10, 64'hFF,   5'b00011, 1};
        tbl[7]  = '{0, 64'h2A, 64'h00, 4'd11, 64'h2A,   5'b00001, 1};
        tbl[8]  = '{0, 64'h05, 64'h05, 4'd8,  64'h01,   5'b00000, 1};
        tbl[9]  = '{0, 64'h05, 64'h03, 4'd13, 64'h00,   5'b10000, 1};
        tbl[10] = '{1, 64'h0001, 64'h1F, 4'd5, 64'h8000, 5'b00010, 1};
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].op, 1'b1, r, f, l, pv);
            total_cnt++;
            if (r !== tbl[i].res)
                $display("FAIL dir%0d_result: got %h expected %h", i, r, tbl[i].res);
            else pass_cnt++;
            total_cnt++;
            if (f !== tbl[i].flg)
                $display("FAIL dir%0d_flags: got %b expected %b", i, f, tbl[i].flg);
            else pass_cnt++;
            total_cnt++;
            if (l != tbl[i].lat)
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, l, tbl[i].lat);
            else pass_cnt++;
            total_cnt++;
            if (pv !== 1'b0)
                $display("FAIL dir%0d_valid_drop: got %b expected 0", i, pv);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [63:0] r; logic [4:0] f; int l; logic pv;
        logic stray;
        run_op(0, 64'h10, 64'h11, 4'd9, 1'b0, r, f, l, pv);
        in_valid_v[0] = 1'b1; a_v[0] = 64'hFF; b_v[0] = 64'h01; op_v[0] = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_v[0] = {$urandom(), $urandom()};
            total_cnt++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 ||
                res_v[0] !== 64'h10 || flg_v[0] !== 5'b01000)
                $display("FAIL stall_hold%0d: got ov=%b rdy=%b res=%h flg=%b expected ov=1 rdy=0 res=10 flg=01000",
                         i, out_valid_v[0], in_ready_v[0], res_v[0], flg_v[0]);
            else pass_cnt++;
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        total_cnt++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1)
            $display("FAIL stall_release: got ov=%b rdy=%b expected ov=0 rdy=1",
                     out_valid_v[0], in_ready_v[0]);
        else pass_cnt++;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) stray = 1'b1;
        end
        total_cnt++;
        if (stray !== 1'b0)
            $display("FAIL stall_ignored_req: got out_valid %b expected 0", stray);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        logic [63:0] r; logic [4:0] f; int l; logic pv;
        logic stray;
        a_v[0] = 64'd3; b_v[0] = 64'd5; op_v[0] = 4'd9; in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid_v[0] !== 1'b0)
            $display("FAIL busy_reset_ov: got %b expected 0", out_valid_v[0]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_v[0] === 1'b1) stray = 1'b1;
        end
        total_cnt++;
        if (stray !== 1'b0)
            $display("FAIL busy_reset_no_result: got %b expected 0", stray);
        else pass_cnt++;
        run_op(0, 64'd3, 64'd5, 4'd0, 1'b1, r, f, l, pv);
        total_cnt++;
        if (r !== 64'd8 || l != 1)
            $display("FAIL busy_reset_next: got res=%h lat=%0d expected res=08 lat=1", r, l);
        else pass_cnt++;
    endtask

    task automatic test_random(input int k, input int n);
        int w;
        logic [63:0] mask, a, b, r;
        logic [3:0] op;
        logic [4:0] f;
        int l;
        logic pv;
        exp_t e;
        w = 8 << k;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++) begin
            a  = {$urandom(), $urandom()} & mask;
            b  = {$urandom(), $urandom()} & mask;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) b = 64'd0;
            e = model(w, a, b, op);
            run_op(k, a, b, op, 1'b1, r, f, l, pv);
            total_cnt++;
            if (r !== e.res)
                $display("FAIL rand_w%0d_result op=%0d a=%h b=%h: got %h expected %h", w, op, a, b, r, e.res);
            else pass_cnt++;
            total_cnt++;
            if (f !== e.flg)
                $display("FAIL rand_w%0d_flags op=%0d a=%h b=%h: got %b expected %b", w, op, a, b, f, e.flg);
            else pass_cnt++;
            total_cnt++;
            if (l != e.lat)
                $display("FAIL rand_w%0d_latency op=%0d: got %0d expected %0d", w, op, l, e.lat);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = 64'd0; b_v[i] = 64'd0; op_v[i] = 4'd0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_reset_busy();
        test_random(0, 30);
        test_random(1, 40);
        test_random(2, 40);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
